// File: rtl/uart_pkg.sv
// Shared UART definitions: receive FSM states and serial line levels.
// Used by both rx_dsm and tx_asm.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

endpackage

// File: rtl/uart_bit_sync.sv
// Two-flop synchroniser for an asynchronous serial line, plus falling-edge detect.
// All flops reset to the idle line level so that no edge is seen out of reset.
module uart_bit_sync
    import uart_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= IDLE_LEVEL;
            r_sync <= IDLE_LEVEL;
            r_prev <= IDLE_LEVEL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_sync = r_sync;
    // A fall needs a preceding synced 1, so a held-low (break) line never retriggers.
    assign o_fall = r_prev & ~r_sync;

endmodule

// File: rtl/rx_dsm.sv
// UART receive disassembler: samples start/data/[parity]/stop mid-bit and delivers
// each word with error flags on a valid/ready handshake.
module rx_dsm
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  rx_in,
    input  logic                  parity_per_byte,
    input  logic                  ready,
    output logic                  valid,
    output logic [DATA_WIDTH-1:0] data,
    output logic                  parity_error,
    output logic                  frame_error,
    output logic                  overrun,
    output logic                  rx_done,
    output logic                  busy
);

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);
    localparam logic [BAUD_W-1:0] HALF_CNT = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] FULL_CNT = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  LAST_BIT = BIT_W'(DATA_WIDTH - 1);

    logic w_rx;
    logic w_fall;
    logic w_tick;

    rx_state_t             r_state;
    logic [BAUD_W-1:0]     r_baud;
    logic [BIT_W-1:0]      r_bit;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_err;
    logic                  r_valid;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_parity_error;
    logic                  r_frame_error;
    logic                  r_overrun;
    logic                  r_rx_done;

    uart_bit_sync u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_async (rx_in),
        .o_sync  (w_rx),
        .o_fall  (w_fall)
    );

    assign w_tick = (r_baud == FULL_CNT);

    // Handshake: a word is transferred on any cycle where valid & ready; while
    // valid & ~ready, data and flags hold unless a new frame overwrites them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state        <= IDLE;
            r_baud         <= '0;
            r_bit          <= '0;
            r_shift        <= '0;
            r_par_en       <= 1'b0;
            r_par_err      <= 1'b0;
            r_valid        <= 1'b0;
            r_data         <= '0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
            r_rx_done      <= 1'b0;
        end else begin
            r_rx_done <= 1'b0;
            if (r_valid && ready) begin
                r_valid <= 1'b0;
            end
            if (r_state == DATA || r_state == PARITY || r_state == STOP) begin
                r_baud <= w_tick ? '0 : r_baud + 1'b1;
            end

            case (r_state)
                IDLE: begin
                    if (w_fall) begin
                        r_baud    <= '0;
                        r_par_en  <= parity_per_byte;
                        r_par_err <= 1'b0;
                        r_state   <= START;
                    end
                end
                START: begin
                    if (r_baud == HALF_CNT) begin
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= (w_rx == START_BIT) ? DATA : IDLE;
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_tick) begin
                        r_shift <= {w_rx, r_shift[DATA_WIDTH-1:1]};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == LAST_BIT) begin
                            r_state <= r_par_en ? PARITY : STOP;
                        end
                    end
                end
                PARITY: begin
                    if (w_tick) begin
                        r_par_err <= ^{r_shift, w_rx};
                        r_state   <= STOP;
                    end
                end
                STOP: begin
                    // Leave at mid-stop so the next start edge is caught back-to-back.
                    if (w_tick) begin
                        r_data         <= r_shift;
                        r_parity_error <= r_par_err;
                        r_frame_error  <= (w_rx != STOP_BIT);
                        r_overrun      <= r_valid & ~ready;
                        r_valid        <= 1'b1;
                        r_rx_done      <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign valid        = r_valid;
    assign data         = r_data;
    assign parity_error = r_parity_error;
    assign frame_error  = r_frame_error;
    assign overrun      = r_overrun;
    assign rx_done      = r_rx_done;
    assign busy         = (r_state != IDLE);

endmodule
